pill_feeder: RTL and testbench

Feed sequencer that sits directly upstream of the working counters in the bottling datapath. After a start command it produces the paced `pill_pulse` stream and the counter enable `en`. It inserts a fixed bottle-swap interval each time a bottle reaches its pill quota, honours an operator pause, and stops permanently when the counters report `finished`.

---
 rtl/pill_feeder.sv | 157 +++++++++++++++
 tb/tb_pill_feeder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pill_feeder.sv
// Feed sequencer ahead of the working counters: paced pill strobes, bottle-swap gaps,
// operator pause, and a terminal stop once the counters report finished.
module pill_feeder #(
   parameter int PULSE_PERIOD = 50,
   parameter int SWAP_CYCLES  = 200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       pause,
   input  logic       finished,
   input  logic [7:0] pill_setting,
   output logic       en,
   output logic       pill_pulse,
   output logic       swapping,
   output logic       running,
   output logic       done
);

   localparam int PW = $clog2(PULSE_PERIOD);
   localparam int SW = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
   localparam logic [PW-1:0] PERIOD_LAST = PW'(PULSE_PERIOD - 1);
   localparam logic [SW-1:0] SWAP_LAST   = SW'(SWAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_SWAP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] period_q, period_d;
   logic [SW-1:0] swap_q, swap_d;
   logic [6:0]    quota_q, quota_d;
   logic [6:0]    count_q, count_d;

   logic [3:0]    tens_c, ones_c;
   logic [6:0]    quota_c;
   logic [6:0]    count_inc_c;
   logic          fire_c;
   logic          bottle_full_c;

   // BCD digits above 9 saturate to 9 before the quota is formed.
   always_comb begin
      tens_c  = (pill_setting[7:4] > 4'd9) ? 4'd9 : pill_setting[7:4];
      ones_c  = (pill_setting[3:0] > 4'd9) ? 4'd9 : pill_setting[3:0];
      quota_c = 7'(tens_c) * 7'd10 + 7'(ones_c);
   end

   // A pulse is suppressed by pause, by finished, and always when the quota is zero.
   always_comb begin
      count_inc_c   = count_q + 7'd1;
      fire_c        = (state_q == S_FEED) && !finished && !pause &&
                      (quota_q != 7'd0) && (period_q == PERIOD_LAST);
      bottle_full_c = fire_c && (count_inc_c == quota_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         period_q <= '0;
         swap_q   <= '0;
         quota_q  <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         swap_q   <= swap_d;
         quota_q  <= quota_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      swap_d   = swap_q;
      quota_d  = quota_q;
      count_d  = count_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_FEED;
               quota_d  = quota_c;
               period_d = '0;
               count_d  = '0;
            end
         end
         S_FEED: begin
            if (finished) begin
               state_d = S_DONE;
            end else if (!pause) begin
               if (period_q == PERIOD_LAST) begin
                  period_d = '0;
               end else begin
                  period_d = period_q + 1'b1;
               end
               if (fire_c) begin
                  count_d = count_inc_c;
               end
               if (bottle_full_c) begin
                  state_d = S_SWAP;
                  count_d = '0;
                  swap_d  = '0;
               end
            end
         end
         S_SWAP: begin
            if (finished) begin
               state_d = S_DONE;
            end else if (!pause) begin
               if (swap_q == SWAP_LAST) begin
                  state_d  = S_FEED;
                  period_d = '0;
               end else begin
                  swap_d = swap_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // en stays high in DONE so the counters keep presenting a valid finished.
   always_comb begin
      en         = 1'b0;
      running    = 1'b0;
      swapping   = 1'b0;
      done       = 1'b0;
      pill_pulse = 1'b0;
      case (state_q)
         S_FEED: begin
            en         = 1'b1;
            running    = 1'b1;
            pill_pulse = fire_c;
         end
         S_SWAP: begin
            en       = 1'b1;
            swapping = 1'b1;
         end
         S_DONE: begin
            en   = 1'b1;
            done = 1'b1;
         end
         default: begin
            en = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pill_feeder.sv
// Randomized and directed bench for pill_feeder against an event-time reference model
// driven by a simple working-counters model that closes the finished loop.
module tb_pill_feeder;

   localparam int P = 4;
   localparam int S = 5;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       pause;
   logic       finished;
   logic [7:0] pill_setting;
   logic       en, pill_pulse, swapping, running, done;

   int checks = 0;
   int errors = 0;

   // Working-counters model: counts pulses, reports finished once bottles x quota are filled.
   int fin_cnt;
   int fin_target;
   bit fin_zero;
   assign finished = en && (fin_zero || (fin_cnt >= fin_target));

   always #5 clk = ~clk;

   pill_feeder #(
      .PULSE_PERIOD(P),
      .SWAP_CYCLES (S)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .pause       (pause),
      .finished    (finished),
      .pill_setting(pill_setting),
      .en          (en),
      .pill_pulse  (pill_pulse),
      .swapping    (swapping),
      .running     (running),
      .done        (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int quota_of(input logic [7:0] s);
      int t;
      int o;
      t = int'(s[7:4]);
      o = int'(s[3:0]);
      if (t > 9) t = 9;
      if (o > 9) o = 9;
      return 10 * t + o;
   endfunction

   // v = number of active (unpaused FEED/SWAP) cycles consumed once the current one completes.
   // Each bottle occupies q*P active cycles of feeding followed by S of swapping.
   function automatic bit pulse_due(input int v, input int q, input int blk);
      int r;
      r = v % blk;
      return ((r % P) == 0) && (r >= P) && (r <= q * P);
   endfunction

   task automatic run_scenario(input string name, input logic [7:0] ps, input int bottles,
                               input int pmode, input int plo, input int plen, input int pprob,
                               input int reset_at, input int efirst, input int enth, input int ent,
                               input int eswap, input int edone, input int ecount);
      int q, blk, a, tdone, k, c, nexp, first_sw, first_dn, es;
      bit started, ep;
      int ptimes[$];
      logic [4:0] exp_o, got_o;
      q        = quota_of(ps);
      blk      = q * P + S;
      a        = 0;
      nexp     = 0;
      started  = 1'b0;
      first_sw = -1;
      first_dn = -1;
      k        = int'($urandom_range(2, 5));
      pill_setting = ps;
      fin_cnt    = 0;
      fin_target = q * bottles;
      fin_zero   = (q == 0) || (bottles == 0);
      tdone      = fin_zero ? k + 2 : (1 << 30);
      for (c = 0; c < 3000; c++) begin
         start = (c == k) || (c == tdone + 2);
         case (pmode)
            1:       pause = (c >= k + plo) && (c < k + plo + plen);
            2:       pause = (int'($urandom_range(0, 99)) < pprob);
            default: pause = 1'b0;
         endcase
         @(negedge clk);
         if (!started)      es = 0;
         else if (c >= tdone) es = 3;
         else if (q == 0)   es = 1;
         else               es = ((a % blk) >= q * P) ? 2 : 1;
         ep = 1'b0;
         if (es == 1 && !pause && q > 0 && bottles > 0) ep = pulse_due(a + 1, q, blk);
         exp_o = {es != 0, es == 1, es == 2, es == 3, ep};
         got_o = {en, running, swapping, done, pill_pulse};
         check($sformatf("%s outputs rel %0d", name, c - k), 32'(got_o), 32'(exp_o));
         if (got_o[0] === 1'b1) ptimes.push_back(c - k);
         if (swapping === 1'b1 && first_sw < 0) first_sw = c - k;
         if (done === 1'b1 && first_dn < 0) first_dn = c - k;
         if (ep) begin
            nexp++;
            if (nexp == q * bottles) tdone = c + 2;
         end
         if (c == k + reset_at) begin
            #2 reset_n = 1'b0;
            #1 check($sformatf("%s async reset", name), 32'({en, running, swapping, done, pill_pulse}), 32'd0);
            @(posedge clk);
            #1 reset_n = 1'b1;
            start = 1'b0;
            pause = 1'b0;
            $display("scenario %s: reset asserted at rel %0d, pulses before reset %0d", name, reset_at, ptimes.size());
            return;
         end
         @(posedge clk);
         #1;
         if (got_o[0] === 1'b1) fin_cnt++;
         if (es == 0 && start) begin
            started = 1'b1;
            a = 0;
         end else if ((es == 1 || es == 2) && !pause) begin
            a++;
         end
         if (tdone < (1 << 30) && c >= tdone + 5) break;
      end
      start = 1'b0;
      pause = 1'b0;
      check($sformatf("%s within cycle budget", name), 32'(c < 3000), 32'd1);
      if (efirst >= 0) check($sformatf("%s first pulse", name), 32'(ptimes.size() > 0 ? ptimes[0] : -1), 32'(efirst));
      if (enth > 0) check($sformatf("%s pulse %0d", name, enth), 32'(ptimes.size() >= enth ? ptimes[enth-1] : -1), 32'(ent));
      if (eswap >= 0) check($sformatf("%s first swap", name), 32'(first_sw), 32'(eswap));
      if (edone >= 0) check($sformatf("%s first done", name), 32'(first_dn), 32'(edone));
      check($sformatf("%s pulse count", name), 32'(ptimes.size()), 32'(ecount >= 0 ? ecount : q * bottles));
      $display("scenario %s: setting=%h quota=%0d bottles=%0d pulses=%0d swap@%0d done@%0d",
               name, ps, q, bottles, ptimes.size(), first_sw, first_dn);
   endtask

   initial begin
      reset_n      = 1'b0;
      start        = 1'b0;
      pause        = 1'b0;
      pill_setting = 8'h00;
      fin_cnt      = 0;
      fin_target   = 0;
      fin_zero     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", 32'({en, running, swapping, done, pill_pulse}), 32'd0);
      reset_n = 1'b1;

      //            name          set    bot pm lo len pr rst  first nth nt  swap done cnt
      run_scenario("basic",      8'h10, 1,  0, 0, 0,  0, -1,  4,    2,  8,  41,  42,  10);
      run_scenario("swap",       8'h03, 2,  0, 0, 0,  0, -1,  4,    4,  21, 13,  31,  6);
      run_scenario("pause_feed", 8'h03, 1,  1, 2, 7,  0, -1,  11,   2,  15, 20,  21,  3);
      run_scenario("pause_swap", 8'h03, 2,  1, 14, 7, 0, -1,  4,    4,  28, 13,  38,  6);
      run_scenario("zero",       8'h00, 2,  0, 0, 0,  0, -1,  -1,   0,  0,  -1,  2,   0);
      run_scenario("clamp",      8'hA5, 1,  0, 0, 0,  0, -1,  4,    95, 380, 381, 382, 95);
      run_scenario("reset_mid",  8'h03, 2,  0, 0, 0,  0, 15,  -1,   0,  0,  -1,  -1,  -1);
      run_scenario("after_rst",  8'h10, 1,  0, 0, 0,  0, -1,  4,    2,  8,  41,  42,  10);

      for (int i = 0; i < 6; i++) begin
         logic [7:0] rs;
         rs = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
         run_scenario($sformatf("rand%0d", i), rs, int'($urandom_range(0, 3)), 2, 0, 0,
                      int'($urandom_range(0, 30)), -1, -1, 0, 0, -1, -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
